alu_mdu_pipe: RTL and testbench

- Parametrised execute-stage unit replacing the combinational ALU.
- Contains two operand forwarding muxes, a single-cycle integer ALU and an iterative unsigned multiply/divide unit.
- Sits between DEC_ALU and ALU_MEM. Uses valid/ready handshakes on both sides, so the pipeline can stall while a multi-cycle op runs.
- Output is registered.

---
 rtl/alu_mdu_pipe.sv | 118 +++++++++++
 tb/tb_alu_mdu_pipe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_mdu_pipe.sv
// alu_mdu_pipe: execute stage with operand forwarding, single-cycle ALU and
// iterative unsigned multiply/divide behind valid/ready handshakes.
module alu_mdu_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] fwd_alu_mem,
    input  logic [DATA_W-1:0] fwd_mem_wb,
    input  logic [1:0]        sel1,
    input  logic [1:0]        sel2,
    input  logic [DATA_W-1:0] imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);
    localparam int SH_W = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] opnd_q, opnd_d, result_q, result_d;
    logic hi_q, hi_d, out_valid_q, out_valid_d;
    logic [DATA_W-1:0] src_a, src_b, op_b, alu_res;
    logic [DATA_W:0] mul_sum, div_sh, div_diff;
    logic accept, div_ge;
    assign src_a = sel1 == 2'd1 ? fwd_alu_mem : sel1 == 2'd2 ? fwd_mem_wb : rs1_data;
    assign src_b = sel2 == 2'd1 ? fwd_alu_mem : sel2 == 2'd2 ? fwd_mem_wb : rs2_data;
    assign op_b = use_imm ? imm : src_b;
    assign in_ready = state_q == IDLE && (!out_valid_q || out_ready);
    assign accept = in_valid && in_ready;
    assign busy = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign result = result_q;
    always_comb begin
        alu_res = '0;
        case (op)
            4'd0: alu_res = src_a + op_b;
            4'd1: alu_res = src_a - op_b;
            4'd2: alu_res = src_a & op_b;
            4'd3: alu_res = src_a | op_b;
            4'd4: alu_res = src_a ^ op_b;
            4'd5: alu_res = src_a << op_b[SH_W-1:0];
            4'd6: alu_res = src_a >> op_b[SH_W-1:0];
            4'd7: alu_res = DATA_W'($signed(src_a) >>> op_b[SH_W-1:0]);
            4'd8: alu_res = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(op_b)};
            4'd9: alu_res = {{(DATA_W-1){1'b0}}, src_a < op_b};
            default: alu_res = '0;
        endcase
    end
    // acc holds {high, low} of the product, or {remainder, quotient/dividend}
    assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, acc_q[0] ? opnd_q : {DATA_W{1'b0}}};
    assign div_sh = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_ge = !div_diff[DATA_W];
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        opnd_d = opnd_q;
        hi_d = hi_q;
        result_d = result_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            IDLE: if (accept) begin
                if (op inside {[4'd10:4'd13]}) begin
                    state_d = op[2] ? DIV : MUL;
                    hi_d = op[0];
                    cnt_d = '0;
                    acc_d = {{DATA_W{1'b0}}, op[2] ? src_a : op_b};
                    opnd_d = op[2] ? op_b : src_a;
                end else begin
                    result_d = alu_res;
                    out_valid_d = 1'b1;
                end
            end
            MUL, DIV: begin
                acc_d = state_q == MUL ? {mul_sum, acc_q[DATA_W-1:1]}
                      : {div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0], acc_q[DATA_W-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                state_d = cnt_q == CNT_W'(DATA_W - 1) ? DONE : state_q;
            end
            DONE: if (!out_valid_q || out_ready) begin
                result_d = hi_q ? acc_q[2*DATA_W-1:DATA_W] : acc_q[DATA_W-1:0];
                out_valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            opnd_q <= '0;
            hi_q <= 1'b0;
            result_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opnd_q <= opnd_d;
            hi_q <= hi_d;
            result_q <= result_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_mdu_pipe.sv
// tb_alu_mdu_pipe: directed vectors with a result scoreboard and a decoupled monitor.
module tb_alu_mdu_pipe;
    localparam int W = 32;
    logic clk = 0, rst = 1, in_valid = 0, in_ready, use_imm = 0, out_valid, out_ready = 1, busy;
    logic [3:0] op = 0;
    logic [1:0] sel1 = 0, sel2 = 0;
    logic [W-1:0] rs1_data = 0, rs2_data = 0, fwd_alu_mem = 0, fwd_mem_wb = 0, imm = 0, result;
    typedef struct {logic [W-1:0] exp; int lat; int acc_cyc; int id;} ent_t;
    ent_t sb[$];
    int checks = 0, errors = 0, cyc = 0, n_acc = 0;

    alu_mdu_pipe #(.DATA_W(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .use_imm(use_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_alu_mem(fwd_alu_mem), .fwd_mem_wb(fwd_mem_wb), .sel1(sel1), .sel2(sel2),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic set_op(logic [3:0] o, logic [W-1:0] a, logic [W-1:0] b);
        op = o; rs1_data = a; rs2_data = b; sel1 = 0; sel2 = 0; use_imm = 0; in_valid = 1;
    endtask

    // lat: cycles from the accepting edge to out_valid; -1 skips the latency check
    task automatic wait_accept(logic [W-1:0] exp, int lat, int id);
        logic rdy;
        int n = 0;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); n++;
        end while (!rdy && n < 200);
        #1; in_valid = 0; n_acc = n;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL accept_timeout id %0d", id);
        end else sb.push_back('{exp, lat, cyc, id});
    endtask

    task automatic run(logic [3:0] o, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] exp, int lat, int id);
        set_op(o, a, b);
        wait_accept(exp, lat, id);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        chk("drain_pending", W'(sb.size()), 0);
    endtask

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk($sformatf("result_id%0d", e.id), result, e.exp);
                    if (e.lat >= 0) chk($sformatf("latency_id%0d", e.id), W'(cyc - e.acc_cyc), W'(e.lat));
                end
            end
        end
    end

    initial begin
        logic bad;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); @(negedge clk); rst = 0;
        #1 chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;
        set_op(0, 100, 200); sel1 = 1; sel2 = 2; fwd_alu_mem = 5; fwd_mem_wb = 7;
        wait_accept(12, 0, 1);
        fwd_alu_mem = 99; fwd_mem_wb = 99;
        set_op(0, 100, 23); sel1 = 3; sel2 = 3;
        wait_accept(123, 0, 2);
        set_op(0, 10, 555); use_imm = 1; imm = 32'hFFFF_FFFD;
        wait_accept(7, 0, 3);
        run(1, 3, 5, 32'hFFFF_FFFE, 0, 4);
        run(7, 32'h8000_0000, 4, 32'hF800_0000, 0, 5);
        chk("b2b_sra", n_acc, 1);
        run(8, 32'hFFFF_FFFF, 1, 1, 0, 6);
        chk("b2b_slt", n_acc, 1);
        run(9, 32'hFFFF_FFFF, 1, 0, 0, 7);
        chk("b2b_sltu", n_acc, 1);
        run(2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0, 8);
        run(3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 0, 9);
        run(4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 0, 10);
        run(5, 1, 31, 32'h8000_0000, 0, 11);
        run(6, 32'h8000_0000, 33, 32'h4000_0000, 0, 12);
        run(14, 5, 6, 0, 0, 13);
        run(15, 5, 6, 0, 0, 14);
        run(0, 32'hFFFF_FFFF, 1, 0, 0, 15);
        run(11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 16);
        bad = 0;
        repeat (33) begin
            @(negedge clk);
            if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1;
        end
        chk("mul_busy_stall", bad, 0);
        run(10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 33, 17);
        run(10, 0, 12345, 0, 33, 18);
        run(12, 100, 7, 14, 33, 19);
        run(13, 100, 7, 2, 33, 20);
        run(12, 5, 0, 32'hFFFF_FFFF, 33, 21);
        run(13, 9, 0, 9, 33, 22);
        wait_drain();
        out_ready = 0;
        run(0, 20, 22, 42, -1, 23);
        set_op(1, 50, 8);
        repeat (5) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result", result, 42);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 out_ready = 1;
        wait_accept(42, 0, 24);
        chk("accept_on_release", n_acc, 1);
        wait_drain();
        set_op(12, 1000, 3);
        wait_accept(333, -1, 25);
        repeat (10) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        sb.delete();
        @(negedge clk); rst = 0;
        #1 chk("in_ready_after_midrst", in_ready, 1);
        @(posedge clk); #1;
        run(0, 1, 1, 2, 0, 26);
        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
